// File: rtl/x_ram_sweep.sv
// Single-port distributed RAM: synchronous write, asynchronous read, and a
// sequencer that fills every word with INIT_VAL after reset and on CLR.
module x_ram_sweep #(
    parameter int               WIDTH      = 8,
    parameter int               ADDR_WIDTH = 4,
    parameter logic [WIDTH-1:0] INIT_VAL   = '0,
    parameter                   LOC        = "UNPLACED"
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [ADDR_WIDTH-1:0] ADR,
    input  logic [WIDTH-1:0]      I,
    input  logic                  WE,
    input  logic                  CLR,
    output logic [WIDTH-1:0]      O,
    output logic                  BUSY
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {SWEEP, IDLE} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_adr;
    logic [WIDTH-1:0]      wr_dat;
    logic [WIDTH-1:0]      mem [DEPTH];

    // Placement hint only; carries no logic.
    if (LOC == "") begin : g_unplaced
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= SWEEP;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        wr_en     = 1'b0;
        wr_adr    = ADR;
        wr_dat    = I;
        case (state)
            SWEEP: begin
                wr_en  = 1'b1;
                wr_adr = cnt;
                wr_dat = INIT_VAL;
                if (cnt == LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            IDLE: begin
                // CLR takes priority and drops a coincident user write.
                if (CLR) begin
                    state_nxt = SWEEP;
                    cnt_nxt   = '0;
                end else if (WE) begin
                    wr_en = 1'b1;
                end
            end
            default: begin
                state_nxt = SWEEP;
                cnt_nxt   = '0;
            end
        endcase
    end

    // The array itself is never reset; a low RST_N only suppresses the write.
    always_ff @(posedge CLK) begin
        if (wr_en && RST_N)
            mem[wr_adr] <= wr_dat;
    end

    assign O    = mem[ADR];
    assign BUSY = (state == SWEEP);

endmodule
